// File: rtl/shuangyu_uart_tx.sv
// shuangyu_uart_tx: FIFO-buffered UART transmitter, 8N1 LSB first on one pin.
// Define UART_PARITY_EN to insert an even-parity bit between data and stop.
module shuangyu_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [7:0] in_data,
  input  logic in_valid,
  output logic in_ready,
  output logic tx,
  output logic busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic tx_d, bit_tick, push, pop;
`ifdef UART_PARITY_EN
  logic par, par_n;
`endif
  assign in_ready = fifo_level != FULL;
  assign busy = state != IDLE || fifo_level != '0;
  assign push = in_valid && in_ready;
  assign pop = state == IDLE && fifo_level != '0;
  assign bit_tick = baud == BAUD_MAX;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      fifo_level <= fifo_level + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      shift <= '0;
      tx <= 1'b1;
`ifdef UART_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_cnt <= bit_cnt_n;
      shift <= shift_n;
      tx <= tx_d;
`ifdef UART_PARITY_EN
      par <= par_n;
`endif
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = pop ? START : IDLE;
      START: state_n = bit_tick ? DATA : START;
`ifdef UART_PARITY_EN
      DATA: state_n = bit_tick && bit_cnt == 3'd7 ? PARITY : DATA;
      PARITY: state_n = bit_tick ? STOP : PARITY;
`else
      DATA: state_n = bit_tick && bit_cnt == 3'd7 ? STOP : DATA;
`endif
      STOP: state_n = bit_tick ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
    baud_n = state == IDLE || bit_tick ? '0 : baud + 1'b1;
    bit_cnt_n = state != DATA ? '0 : bit_cnt + 3'(bit_tick);
    shift_n = pop ? mem[rd_ptr] : state == DATA && bit_tick ? shift >> 1 : shift;
`ifdef UART_PARITY_EN
    par_n = pop ? ^mem[rd_ptr] : par;
`endif
  end
  // tx is registered from the next-state view so each bit lands on the edge that enters it
  always_comb begin
`ifdef UART_PARITY_EN
    tx_d = state_n == PARITY ? par_n : 1'b1;
`else
    tx_d = 1'b1;
`endif
    tx_d = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : tx_d;
  end
endmodule

// File: tb/tb_shuangyu_uart_tx.sv
// tb_shuangyu_uart_tx: random-stimulus bench checking the transmitter against a
// frame-timeline model and a line decoder; honours UART_PARITY_EN.
module tb_shuangyu_uart_tx;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
  localparam logic [10:0] SEQ_A5 = 11'b101_0100_1010;
`else
  localparam int NB = 10;
  localparam logic [10:0] SEQ_A5 = 11'b011_0100_1010;
`endif
  logic clk, rst, in_valid, in_ready, tx, busy;
  logic [7:0] in_data;
  logic [2:0] fifo_level;
  int n_pass, n_total;
  logic [7:0] mq[$];
  int t, cyc, exp_lvl, max_lvl;
  logic [NB-1:0] fb;
  logic exp_tx, exp_busy, exp_rdy, mrst, st, pu;
  logic [7:0] b;
  int rx_cnt;
  logic [7:0] rx_b;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];

  shuangyu_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx(tx),
    .busy(busy),
    .fifo_level(fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // Model: a FIFO queue plus the time elapsed in the current frame.
  initial begin
    t = -1;
    cyc = 0;
    mrst = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      mrst = rst;
      pu = in_valid && mq.size() < DEPTH;
      st = t < 0 && mq.size() > 0;
      if (rst) begin
        mq.delete();
        t = -1;
      end else begin
        if (t >= 0) t = (t + 1 == NB * CPB) ? -1 : t + 1;
        else if (st) begin
          b = mq.pop_front();
`ifdef UART_PARITY_EN
          fb = {1'b1, ^b, b, 1'b0};
`else
          fb = {1'b1, b, 1'b0};
`endif
          t = 0;
        end
        if (pu) mq.push_back(in_data);
      end
      exp_tx = t < 0 ? 1'b1 : fb[t / CPB];
      exp_busy = t >= 0 || mq.size() != 0;
      exp_lvl = mq.size();
      exp_rdy = mq.size() != DEPTH;
    end
  end

  initial begin
    max_lvl = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("tx", tx, exp_tx);
      check("busy", busy, exp_busy);
      check("level", fifo_level, exp_lvl);
      check("ready", in_ready, exp_rdy);
      if (fifo_level > max_lvl) max_lvl = fifo_level;
    end
  end

  // Line decoder: samples mid-bit from the first low level of each frame.
  initial begin
    rx_cnt = -1;
    rx_b = '0;
    forever begin
      @(negedge clk);
      if (mrst) rx_cnt = -1;
      else if (rx_cnt < 0) begin
        if (tx === 1'b0) rx_cnt = 0;
      end else begin
        rx_cnt++;
        if (rx_cnt % CPB == CPB / 2) begin
          if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) rx_b[rx_cnt / CPB - 1] = tx;
          else if (rx_cnt / CPB == NB - 1) begin
            rxq.push_back(rx_b);
            rx_cnt = -1;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] v);
    int n = 0;
    in_valid = 1'b1;
    in_data = v;
    while (in_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_rx(input string nm);
    check({nm, "_count"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < rxq.size(); i++) check(nm, rxq[i], expq[i]);
  endtask

  initial begin
    logic [10:0] seq;
    logic [7:0] d;
    logic a;
    int n0, acc, lows;
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", in_ready, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    seq = SEQ_A5;
    rxq.delete();
    expq.delete();
    expq.push_back(8'hA5);
    send(8'hA5);
    n0 = cyc;
    for (int i = 0; i < NB; i++) begin
      wait_cyc(n0 + 1 + CPB * i);
      check("a5_bit", tx, seq[i]);
    end
    wait_cyc(n0 + NB * CPB);
    check("a5_busy_hold", busy, 1);
    wait_cyc(n0 + NB * CPB + 1);
    check("a5_busy_fall", busy, 0);
    check_rx("a5_decode");

    wait_idle();
    rxq.delete();
    expq.delete();
    for (int i = 1; i <= 6; i++) expq.push_back(8'(i));
    in_valid = 1'b1;
    d = 8'd1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_data = d;
      a = in_ready;
      @(negedge clk);
      if (a) begin
        acc++;
        d++;
      end
    end
    check("bp_accepted", acc, 5);
    check("bp_ready", in_ready, 0);
    check("bp_level", fifo_level, 4);
    n0 = 0;
    while (acc < 6 && n0 < 200) begin
      in_data = d;
      a = in_ready;
      @(negedge clk);
      if (a) begin
        acc++;
        d++;
      end
      n0++;
    end
    in_valid = 1'b0;
    check("bp_accepted_all", acc, 6);
    wait_idle();
    check_rx("bp_decode");

    rxq.delete();
    expq.delete();
    max_lvl = 0;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 25)) @(negedge clk);
      expq.push_back(8'(16 + i));
      send(8'(16 + i));
    end
    wait_idle();
    check_rx("wrap_decode");
    check("wrap_level_bound", max_lvl <= DEPTH, 1);

    rxq.delete();
    expq.delete();
    for (int i = 0; i < 30; i++) begin
      d = 8'($urandom);
      repeat ($urandom_range(0, 3) == 0 ? $urandom_range(0, 60) : 0) @(negedge clk);
      expq.push_back(d);
      send(d);
    end
    wait_idle();
    check_rx("rand_decode");

    send(8'hFF);
    n0 = cyc;
    send(8'h33);
    send(8'h44);
    check("mid_level", fifo_level, 2);
    wait_cyc(n0 + 17);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", tx, 1);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_busy", busy, 0);
    rst = 1'b0;
    rxq.delete();
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("post_rst_lows", lows, 0);
    check("post_rst_frames", rxq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/shuangyu_uart_tx.md
Name: shuangyu_uart_tx

Overview:
Downstream output stage inside tt_um_shuangyu_top. It takes result bytes from the core over a valid/ready handshake and buffers them in a small FIFO. It serializes each byte as 8N1 UART, LSB first, onto a single uio output pin. This lets the board bench or host read results over one wire instead of sampling uo_out in parallel.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (115200 baud at 50 MHz); legal range >= 2
FIFO_DEPTH, 4, number of byte entries; power of two, >= 2

Ports:
clk  input  1  system clock, the same clk as the tt_um top
rst  input  1  synchronous active-high reset; the top drives it from ~rst_n
in_data  input  8  byte to transmit
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block can accept a byte this cycle
tx  output  1  UART line; idles high
busy  output  1  high while a frame is in progress or the FIFO is non-empty
fifo_level  output  $clog2(FIFO_DEPTH)+1  number of bytes currently held in the FIFO

Behaviour:
- Reset (synchronous, active-high, on clk rising edge) gives:
  - tx=1, busy=0, fifo_level=0, in_ready=1
  - FSM in IDLE, baud and bit counters at 0
  - Reset has priority over all other events.
- Reset mid-frame: the frame is abandoned and FIFO contents are discarded. tx reads 1 on the cycle after the reset edge.
- Handshake rules:
  - A push occurs on a rising edge where in_valid && in_ready.
  - in_ready = (fifo_level != FIFO_DEPTH), combinational from registered state.
  - in_valid while in_ready=0 is ignored and the byte is not stored. The producer must hold in_data until it is accepted.
- FIFO:
  - Circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH.
  - A push and a pop in the same cycle leave fifo_level unchanged.
  - No push is possible when full, even if a pop happens in the same cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if fifo_level != 0, pop the head byte into the shift register and go to START. Otherwise stay in IDLE with tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_cnt=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. After bit_cnt reaches 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing and latency:
  - The baud counter counts 0..CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide.
  - Byte pushed at edge N with the FSM in IDLE and FIFO empty: pop at edge N+1, tx falls low after edge N+1.
  - Back-to-back frames: IDLE lasts exactly 1 cycle between STOP and the next START. The line therefore sees stop-bit + 1 clock of idle.
  - Frame length is 10*CLKS_PER_BIT cycles.
- busy = (state != IDLE) || (fifo_level != 0).
- tx is driven from a flop, so it is glitch-free.

Optional Feature:
Macro UART_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT.
- Undefined: plain 8N1 as above, with no PARITY state or logic.

Test Plan (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset: hold rst=1 for 3 cycles -> tx=1, busy=0, fifo_level=0, in_ready=1.
- Single byte: push 0xA5, then sample tx every 4 cycles starting 1 cycle after the push edge -> bit sequence 0,1,0,1,0,0,1,0,1,1. busy falls 41 cycles after the push edge.
- Parity (UART_PARITY_EN defined), same push of 0xA5 -> sequence 0,1,0,1,0,0,1,0,1,0,1 (parity 0), 44 cycles total.
- Backpressure: hold in_valid=1 with bytes 0x01..0x06 -> exactly 5 bytes accepted (1 in shifter + 4 in FIFO), then in_ready=0 and fifo_level=4. Later, 6 frames decode in order as 0x01..0x06 with no loss or duplication.
- Pointer wrap: send 10 sequential bytes 0x10..0x19 with random in_valid gaps -> all 10 bytes decode in order, and fifo_level never exceeds 4.
- Reset mid-frame: assert rst during DATA bit 3 of 0xFF while 2 further bytes are queued -> tx=1 next cycle, fifo_level=0, and no further frames appear over 100 cycles.
